// File: rtl/adv_pkg.sv
// Shared types and constants for the adventure-game move driver.
// The room vector is one-hot: bit i marks room s<i>.
package adv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHORD  = 3'd1,
    DRIVE  = 3'd2,
    WAIT   = 3'd3,
    LOCKED = 3'd4
  } move_state_t;

  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;

  localparam int ROOM_W     = 7;
  localparam int ROOM_CAVE  = 0;
  localparam int ROOM_S1    = 1;
  localparam int ROOM_S2    = 2;
  localparam int ROOM_S3    = 3;
  localparam int ROOM_S4    = 4;
  localparam int ROOM_S5    = 5;
  localparam int ROOM_GRAVE = 6;

  // An all-zero room vector appears while the game moves between rooms; it never counts.
  function automatic logic room_changed(input logic [ROOM_W-1:0] now_room,
                                        input logic [ROOM_W-1:0] snap_room);
    return (now_room != snap_room) && (now_room != {ROOM_W{1'b0}});
  endfunction

endpackage

// File: rtl/adv_move_driver_if.sv
// Player-side bundle between buttons/game and the move driver.
// master = the driver; slave = the game/button side.
interface adv_move_driver_if;
  import adv_pkg::*;

  logic              btn_n;
  logic              btn_s;
  logic              btn_e;
  logic              btn_w;
  logic [ROOM_W-1:0] room;
  logic              win;
  logic              dead;
  logic              dir_n;
  logic              dir_s;
  logic              dir_e;
  logic              dir_w;
  logic              busy;
  logic              move_ok;
  logic              move_blocked;
  logic [7:0]        moves;
  logic              locked;

  modport master (
    input  btn_n, btn_s, btn_e, btn_w, room, win, dead,
    output dir_n, dir_s, dir_e, dir_w, busy, move_ok, move_blocked, moves, locked
  );

  modport slave (
    output btn_n, btn_s, btn_e, btn_w, room, win, dead,
    input  dir_n, dir_s, dir_e, dir_w, busy, move_ok, move_blocked, moves, locked
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and counting debouncer for one raw button.
// press is a one-cycle pulse in the first cycle the debounced level reads high.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;
  logic          flip_s;

  assign flip_s = (sync2_r != level_r) && (cnt_r == CW'(DEBOUNCE_CYCLES - 1));
  assign press  = press_r;

  // Synchronize, count consecutive mismatches, flip the level once the count completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press_r <= flip_s & ~level_r;
      if (flip_s) begin
        level_r <= ~level_r;
        cnt_r   <= {CW{1'b0}};
      end else if (sync2_r != level_r) begin
        cnt_r   <= cnt_r + CW'(1);
      end else begin
        cnt_r   <= {CW{1'b0}};
      end
    end
  end

endmodule

// File: rtl/adv_move_driver.sv
// Turns debounced button chords into held direction commands for the room FSM,
// reports ok/blocked per command and locks out input after a win or death.
module adv_move_driver
  import adv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CHORD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input logic                  clk,
  input logic                  rst,
  adv_move_driver_if.master    bus
);

  localparam int CCW = (CHORD_CYCLES > 1) ? $clog2(CHORD_CYCLES) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  move_state_t       state_r, state_next;
  logic [3:0]        press_s;
  logic [3:0]        mask_r, mask_next;
  logic [3:0]        dir_r, dir_next;
  logic [CCW-1:0]    ccnt_r, ccnt_next;
  logic [TCW-1:0]    tcnt_r, tcnt_next;
  logic [ROOM_W-1:0] snap_r, snap_next;
  logic [7:0]        moves_r, moves_next;
  logic              ok_r, ok_next;
  logic              blk_r, blk_next;
  logic              busy_r, busy_next;
  logic              locked_r, locked_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_n (.clk(clk), .rst(rst), .btn(bus.btn_n), .press(press_s[DIR_N]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_s (.clk(clk), .rst(rst), .btn(bus.btn_s), .press(press_s[DIR_S]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_e (.clk(clk), .rst(rst), .btn(bus.btn_e), .press(press_s[DIR_E]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_w (.clk(clk), .rst(rst), .btn(bus.btn_w), .press(press_s[DIR_W]));

  // Next state, command, counters and pulses; outputs are registered from these.
  always_comb begin
    state_next = state_r;
    mask_next  = mask_r;
    dir_next   = dir_r;
    ccnt_next  = ccnt_r;
    tcnt_next  = tcnt_r;
    snap_next  = snap_r;
    moves_next = moves_r;
    ok_next    = 1'b0;
    blk_next   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.win || bus.dead) begin
          state_next = LOCKED;
        end else if (press_s != 4'b0000) begin
          mask_next  = press_s;
          ccnt_next  = {CCW{1'b0}};
          state_next = CHORD;
        end else begin
          state_next = IDLE;
        end
      end
      CHORD: begin
        mask_next = mask_r | press_s;
        if (ccnt_r == CCW'(CHORD_CYCLES - 1)) begin
          state_next = DRIVE;
        end else begin
          ccnt_next  = ccnt_r + CCW'(1);
        end
      end
      DRIVE: begin
        dir_next   = mask_r;
        snap_next  = bus.room;
        tcnt_next  = {TCW{1'b0}};
        state_next = WAIT;
      end
      WAIT: begin
        // A room change in the timeout cycle still counts as success.
        if (room_changed(bus.room, snap_r)) begin
          dir_next   = 4'b0000;
          ok_next    = 1'b1;
          moves_next = (moves_r == 8'd255) ? moves_r : moves_r + 8'd1;
          state_next = (bus.win || bus.dead) ? LOCKED : IDLE;
        end else if (tcnt_r == TCW'(TIMEOUT_CYCLES - 1)) begin
          dir_next   = 4'b0000;
          blk_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tcnt_next  = tcnt_r + TCW'(1);
        end
      end
      LOCKED: begin
        dir_next   = 4'b0000;
        state_next = LOCKED;
      end
      default: begin
        dir_next   = 4'b0000;
        state_next = IDLE;
      end
    endcase
    busy_next   = (state_next == CHORD) || (state_next == DRIVE) || (state_next == WAIT);
    locked_next = (state_next == LOCKED);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      mask_r   <= 4'b0000;
      dir_r    <= 4'b0000;
      ccnt_r   <= {CCW{1'b0}};
      tcnt_r   <= {TCW{1'b0}};
      snap_r   <= {ROOM_W{1'b0}};
      moves_r  <= 8'd0;
      ok_r     <= 1'b0;
      blk_r    <= 1'b0;
      busy_r   <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_next;
      mask_r   <= mask_next;
      dir_r    <= dir_next;
      ccnt_r   <= ccnt_next;
      tcnt_r   <= tcnt_next;
      snap_r   <= snap_next;
      moves_r  <= moves_next;
      ok_r     <= ok_next;
      blk_r    <= blk_next;
      busy_r   <= busy_next;
      locked_r <= locked_next;
    end
  end

  assign bus.dir_n        = dir_r[DIR_N];
  assign bus.dir_s        = dir_r[DIR_S];
  assign bus.dir_e        = dir_r[DIR_E];
  assign bus.dir_w        = dir_r[DIR_W];
  assign bus.busy         = busy_r;
  assign bus.move_ok      = ok_r;
  assign bus.move_blocked = blk_r;
  assign bus.moves        = moves_r;
  assign bus.locked       = locked_r;

endmodule
